// File: rtl/rat_pkg.sv
// Shared move encodings, grid limits and the tracker state type.
package rat_pkg;

    localparam logic [1:0] MOVE_UP    = 2'b00;
    localparam logic [1:0] MOVE_RIGHT = 2'b01;
    localparam logic [1:0] MOVE_LEFT  = 2'b10;
    localparam logic [1:0] MOVE_DOWN  = 2'b11;

    localparam logic [3:0] GRID_MAX = 4'd15;
    localparam logic [3:0] START_X  = 4'd0;
    localparam logic [3:0] START_Y  = 4'd0;
    localparam logic [3:0] GOAL_X   = 4'd15;
    localparam logic [3:0] GOAL_Y   = 4'd15;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        COLLECT = 3'd1,
        REPLAY  = 3'd2,
        FIN     = 3'd3,
        ERR     = 3'd4
    } state_t;

endpackage

// File: rtl/move_tracker_if.sv
// Move input channel and position output channel of the move tracker.
interface move_tracker_if;

    logic       move_valid;
    logic [1:0] move;
    logic       move_last;
    logic       move_ready;
    logic [3:0] pos_x;
    logic [3:0] pos_y;
    logic       pos_valid;
    logic       out_ready;

    modport master (
        output move_valid, move, move_last, out_ready,
        input  move_ready, pos_x, pos_y, pos_valid
    );

    modport slave (
        input  move_valid, move, move_last, out_ready,
        output move_ready, pos_x, pos_y, pos_valid
    );

endinterface

// File: rtl/move_fifo.sv
// DEPTH x 2-bit move buffer with show-ahead read; clr empties it like rst.
module move_fifo #(
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clr,
    input  logic                     push,
    input  logic [1:0]               din,
    input  logic                     pop,
    output logic [1:0]               dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [1:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          push_ok;
    logic          pop_ok;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= din;
    end

    // Pointers wrap for free because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/move_tracker.sv
// Collects a path of grid moves, then replays it as a stream of positions.
// Build option MOVE_TRACKER_BOUNDS_CHECK_EN: out-of-grid moves raise error instead of wrapping.
module move_tracker
    import rat_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    move_tracker_if.slave        trk,
    output logic [7:0]           step_count,
    output logic                 done,
    output logic                 at_goal,
    output logic                 error
);

    state_t                   state, state_nxt;
    logic                     fifo_full, fifo_empty;
    logic [1:0]               fifo_dout;
    logic [$clog2(DEPTH):0]   fifo_count;
    logic                     move_ready, push, pop, clr, hs_out, bad;
    logic [3:0]               pos_x, pos_y, nxt_x, nxt_y;
    logic                     pos_valid;

    move_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .clr   (clr),
        .push  (push),
        .din   (trk.move),
        .pop   (pop),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign trk.move_ready = move_ready;
    assign trk.pos_x      = pos_x;
    assign trk.pos_y      = pos_y;
    assign trk.pos_valid  = pos_valid;
    assign push           = trk.move_valid && move_ready;
    assign hs_out         = pos_valid && trk.out_ready;

    // 4-bit arithmetic gives the modulo-16 wrap directly.
    always_comb begin
        nxt_x = pos_x;
        nxt_y = pos_y;
        unique case (fifo_dout)
            MOVE_UP:    nxt_x = pos_x - 4'd1;
            MOVE_RIGHT: nxt_y = pos_y + 4'd1;
            MOVE_LEFT:  nxt_y = pos_y - 4'd1;
            MOVE_DOWN:  nxt_x = pos_x + 4'd1;
        endcase
    end

`ifdef MOVE_TRACKER_BOUNDS_CHECK_EN
    logic oob;
    assign oob = (fifo_dout == MOVE_UP    && pos_x == '0)       ||
                 (fifo_dout == MOVE_DOWN  && pos_x == GRID_MAX) ||
                 (fifo_dout == MOVE_LEFT  && pos_y == '0)       ||
                 (fifo_dout == MOVE_RIGHT && pos_y == GRID_MAX);
    assign bad = pop && oob;
`else
    assign bad = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = COLLECT;
            COLLECT: if (push && trk.move_last) state_nxt = REPLAY;
            REPLAY: begin
                if (bad) state_nxt = ERR;
                else if (hs_out && fifo_count == '0) state_nxt = FIN;
            end
            FIN, ERR: if (start) state_nxt = COLLECT;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        move_ready = (state == COLLECT) && !fifo_full;
        pop        = (state == REPLAY) && !fifo_empty && (!pos_valid || trk.out_ready);
        clr        = start && (state == IDLE || state == FIN || state == ERR);
    end

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            pos_x      <= START_X;
            pos_y      <= START_Y;
            pos_valid  <= 1'b0;
            step_count <= '0;
            done       <= 1'b0;
            at_goal    <= 1'b0;
        end else begin
            if (hs_out && step_count != 8'hff) step_count <= step_count + 8'd1;
            if (pop && !bad) begin
                pos_x     <= nxt_x;
                pos_y     <= nxt_y;
                pos_valid <= 1'b1;
            end else if (hs_out) begin
                pos_valid <= 1'b0;
            end
            if (state == REPLAY && state_nxt == FIN) begin
                done    <= 1'b1;
                at_goal <= (pos_x == GOAL_X) && (pos_y == GOAL_Y);
            end
        end
    end

`ifdef MOVE_TRACKER_BOUNDS_CHECK_EN
    always_ff @(posedge clk) begin
        if (rst || clr) error <= 1'b0;
        else if (bad)   error <= 1'b1;
    end
`else
    assign error = 1'b0;
`endif

endmodule

// File: tb/tb_move_tracker.sv
// Directed bench for move_tracker: DEPTH=16 instance for most scenarios, DEPTH=32 for the goal path.
module tb_move_tracker;
    import rat_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       start16, start32;
    logic [7:0] step16, step32;
    logic       done16, done32, goal16, goal32, err16, err32;

    move_tracker_if bus16();
    move_tracker_if bus32();

    move_tracker #(.DEPTH(16)) dut16 (
        .clk(clk), .rst(rst), .start(start16), .trk(bus16),
        .step_count(step16), .done(done16), .at_goal(goal16), .error(err16)
    );

    move_tracker #(.DEPTH(32)) dut32 (
        .clk(clk), .rst(rst), .start(start32), .trk(bus32),
        .step_count(step32), .done(done32), .at_goal(goal32), .error(err32)
    );

    always #5 clk = ~clk;

    int         n_checks = 0;
    int         n_fail   = 0;
    logic [1:0] path_mv [0:31];
    int         path_len;
    logic [3:0] res_x [0:31];
    logic [3:0] res_y [0:31];
    int         res_n;
    bit         timeout;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        start16 = 0; start32 = 0;
        bus16.move_valid = 0; bus16.move = 0; bus16.move_last = 0; bus16.out_ready = 0;
        bus32.move_valid = 0; bus32.move = 0; bus32.move_last = 0; bus32.out_ready = 0;
    endtask

    task automatic do_reset();
        rst = 1; tick(); rst = 0;
    endtask

    // Start a path on dut16 and push path_mv[0..path_len-1]; start is re-pulsed with move start_at.
    task automatic send_path16(input int start_at);
        timeout = 0;
        start16 = 1; tick(); start16 = 0;
        for (int i = 0; i < path_len; i++) begin
            bus16.move_valid = 1;
            bus16.move       = path_mv[i];
            bus16.move_last  = (i == path_len - 1);
            start16          = (i == start_at);
            for (int c = 0; c < 50 && !bus16.move_ready; c++) tick();
            if (!bus16.move_ready) timeout = 1;
            tick();
        end
        bus16.move_valid = 0; bus16.move_last = 0; start16 = 0;
    endtask

    // Record every position handshake until done/error or the cycle budget runs out.
    task automatic replay16();
        res_n = 0;
        for (int c = 0; c < 200; c++) begin
            if (done16 || err16) break;
            if (bus16.pos_valid && bus16.out_ready && res_n < 32) begin
                res_x[res_n] = bus16.pos_x; res_y[res_n] = bus16.pos_y; res_n++;
            end
            tick();
        end
        if (!(done16 || err16)) timeout = 1;
    endtask

    task automatic test_reset();
        rst = 1; start16 = 1; tick();
        n_checks++;
        if ({bus16.move_ready, bus16.pos_x, bus16.pos_y, bus16.pos_valid, step16, done16, goal16, err16} !== '0) begin
            n_fail++; $display("FAIL reset_outputs: got ready=%b x=%0d y=%0d v=%b step=%0d done=%b goal=%b err=%b, want all 0",
                bus16.move_ready, bus16.pos_x, bus16.pos_y, bus16.pos_valid, step16, done16, goal16, err16);
        end
        rst = 0; start16 = 0; tick();
        n_checks++;
        if (bus16.move_ready !== 1'b0) begin
            n_fail++; $display("FAIL reset_idle_ready: got %b want 0", bus16.move_ready);
        end
    endtask

    task automatic check_basic_path(input string tag);
        logic [3:0] ex [0:3];
        logic [3:0] ey [0:3];
        ex = '{4'd1, 4'd1, 4'd2, 4'd2};
        ey = '{4'd0, 4'd1, 4'd1, 4'd2};
        n_checks++;
        if (timeout !== 1'b0 || res_n !== 4) begin
            n_fail++; $display("FAIL %s_count: got timeout=%b positions=%0d want timeout=0 positions=4", tag, timeout, res_n);
        end
        for (int i = 0; i < 4 && i < res_n; i++) begin
            n_checks++;
            if ({res_x[i], res_y[i]} !== {ex[i], ey[i]}) begin
                n_fail++; $display("FAIL %s_pos%0d: got (%0d,%0d) want (%0d,%0d)", tag, i, res_x[i], res_y[i], ex[i], ey[i]);
            end
        end
        n_checks++;
        if ({step16, done16, goal16, err16, bus16.pos_valid} !== {8'd4, 1'b1, 1'b0, 1'b0, 1'b0}) begin
            n_fail++; $display("FAIL %s_final: got step=%0d done=%b goal=%b err=%b v=%b want step=4 done=1 goal=0 err=0 v=0",
                tag, step16, done16, goal16, err16, bus16.pos_valid);
        end
    endtask

    task automatic load_basic_path();
        path_mv[0] = MOVE_DOWN; path_mv[1] = MOVE_RIGHT;
        path_mv[2] = MOVE_DOWN; path_mv[3] = MOVE_RIGHT;
        path_len = 4;
    endtask

    task automatic test_path();
        load_basic_path();
        bus16.out_ready = 1;
        send_path16(-1);
        replay16();
        check_basic_path("path");
    endtask

    task automatic test_ignored_start();
        load_basic_path();
        bus16.out_ready = 1;
        send_path16(2);
        replay16();
        check_basic_path("ignored_start");
    endtask

    task automatic test_backpressure();
        int acc = 0;
        start16 = 1; tick(); start16 = 0;
        for (int c = 0; c < 40; c++) begin
            bus16.move_valid = 1;
            bus16.move       = acc[0] ? MOVE_RIGHT : MOVE_DOWN;
            bus16.move_last  = (acc == 16);
            if (bus16.move_ready) acc++;
            tick();
        end
        n_checks++;
        if (acc !== 16) begin
            n_fail++; $display("FAIL bp_accepted: got %0d want 16", acc);
        end
        n_checks++;
        if ({bus16.move_ready, bus16.pos_valid, done16} !== 3'b000) begin
            n_fail++; $display("FAIL bp_held: got ready=%b v=%b done=%b want 0 0 0", bus16.move_ready, bus16.pos_valid, done16);
        end
        bus16.move_valid = 0; bus16.move_last = 0;
        do_reset();

        load_basic_path();
        bus16.out_ready = 0;
        send_path16(-1);
        for (int c = 0; c < 5 && !bus16.pos_valid; c++) tick();
        n_checks++;
        if ({bus16.pos_valid, bus16.pos_x, bus16.pos_y} !== {1'b1, 4'd1, 4'd0}) begin
            n_fail++; $display("FAIL stall_first: got v=%b (%0d,%0d) want v=1 (1,0)", bus16.pos_valid, bus16.pos_x, bus16.pos_y);
        end
        for (int c = 0; c < 5; c++) begin
            tick();
            n_checks++;
            if ({bus16.pos_valid, bus16.pos_x, bus16.pos_y, step16} !== {1'b1, 4'd1, 4'd0, 8'd0}) begin
                n_fail++; $display("FAIL stall_cycle%0d: got v=%b (%0d,%0d) step=%0d want v=1 (1,0) step=0",
                    c, bus16.pos_valid, bus16.pos_x, bus16.pos_y, step16);
            end
        end
        bus16.out_ready = 1;
        replay16();
        check_basic_path("stall");
    endtask

    task automatic test_bounds();
        path_mv[0] = MOVE_UP; path_len = 1;
        bus16.out_ready = 1;
        send_path16(-1);
`ifdef MOVE_TRACKER_BOUNDS_CHECK_EN
        begin
            bit saw_valid = 0;
            for (int c = 0; c < 6; c++) begin
                if (bus16.pos_valid) saw_valid = 1;
                tick();
            end
            n_checks++;
            if ({err16, saw_valid, done16, bus16.move_ready} !== 4'b1000) begin
                n_fail++; $display("FAIL bounds_err: got err=%b saw_valid=%b done=%b ready=%b want 1 0 0 0",
                    err16, saw_valid, done16, bus16.move_ready);
            end
            n_checks++;
            if ({bus16.pos_x, bus16.pos_y} !== 8'h00) begin
                n_fail++; $display("FAIL bounds_pos: got (%0d,%0d) want (0,0)", bus16.pos_x, bus16.pos_y);
            end
        end
`else
        replay16();
        n_checks++;
        if (timeout !== 1'b0 || res_n !== 1) begin
            n_fail++; $display("FAIL bounds_count: got timeout=%b positions=%0d want 0 1", timeout, res_n);
        end else begin
            n_checks++;
            if ({res_x[0], res_y[0]} !== {4'd15, 4'd0}) begin
                n_fail++; $display("FAIL bounds_wrap: got (%0d,%0d) want (15,0)", res_x[0], res_y[0]);
            end
        end
        n_checks++;
        if ({err16, done16, step16} !== {1'b0, 1'b1, 8'd1}) begin
            n_fail++; $display("FAIL bounds_flags: got err=%b done=%b step=%0d want 0 1 1", err16, done16, step16);
        end
`endif
    endtask

    task automatic test_reset_mid_replay();
        load_basic_path();
        bus16.out_ready = 1;
        send_path16(-1);
        for (int c = 0; c < 10 && step16 != 8'd2; c++) tick();
        n_checks++;
        if ({step16, bus16.pos_valid, bus16.pos_x, bus16.pos_y} !== {8'd2, 1'b1, 4'd2, 4'd1}) begin
            n_fail++; $display("FAIL midrep_pre: got step=%0d v=%b (%0d,%0d) want step=2 v=1 (2,1)",
                step16, bus16.pos_valid, bus16.pos_x, bus16.pos_y);
        end
        rst = 1; start16 = 1; tick();
        n_checks++;
        if ({bus16.move_ready, bus16.pos_x, bus16.pos_y, bus16.pos_valid, step16, done16, goal16, err16} !== '0) begin
            n_fail++; $display("FAIL midrep_reset: got ready=%b x=%0d y=%0d v=%b step=%0d done=%b goal=%b err=%b want all 0",
                bus16.move_ready, bus16.pos_x, bus16.pos_y, bus16.pos_valid, step16, done16, goal16, err16);
        end
        rst = 0; start16 = 0; tick();
        n_checks++;
        if ({bus16.move_ready, bus16.pos_valid} !== 2'b00) begin
            n_fail++; $display("FAIL midrep_idle: got ready=%b v=%b want 0 0", bus16.move_ready, bus16.pos_valid);
        end
        path_mv[0] = MOVE_RIGHT; path_len = 1;
        send_path16(-1);
        replay16();
        n_checks++;
        if (timeout !== 1'b0 || res_n !== 1 || {res_x[0], res_y[0]} !== {4'd0, 4'd1} || step16 !== 8'd1) begin
            n_fail++; $display("FAIL midrep_restart: got timeout=%b n=%0d (%0d,%0d) step=%0d want 0 1 (0,1) 1",
                timeout, res_n, res_x[0], res_y[0], step16);
        end
    endtask

    task automatic test_goal_path();
        int         acc = 0;
        int         seen = 0;
        logic [3:0] lx = 0, ly = 0;
        bus32.out_ready = 1;
        start32 = 1; tick(); start32 = 0;
        for (int c = 0; c < 60 && acc < 30; c++) begin
            bus32.move_valid = 1;
            bus32.move       = (acc < 15) ? MOVE_DOWN : MOVE_RIGHT;
            bus32.move_last  = (acc == 29);
            if (bus32.move_ready) acc++;
            tick();
        end
        bus32.move_valid = 0; bus32.move_last = 0;
        for (int c = 0; c < 100 && !done32; c++) begin
            if (bus32.pos_valid && bus32.out_ready) begin
                lx = bus32.pos_x; ly = bus32.pos_y; seen++;
            end
            tick();
        end
        n_checks++;
        if (acc !== 30 || seen !== 30 || done32 !== 1'b1) begin
            n_fail++; $display("FAIL goal_count: got accepted=%0d positions=%0d done=%b want 30 30 1", acc, seen, done32);
        end
        n_checks++;
        if ({lx, ly, goal32, step32, err32} !== {4'd15, 4'd15, 1'b1, 8'd30, 1'b0}) begin
            n_fail++; $display("FAIL goal_final: got (%0d,%0d) goal=%b step=%0d err=%b want (15,15) 1 30 0",
                lx, ly, goal32, step32, err32);
        end
    endtask

    initial begin
        rst = 1;
        idle_inputs();
        test_reset();
        test_path();
        test_ignored_start();
        test_backpressure();
        test_bounds();
        test_reset_mid_replay();
        test_goal_path();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
